// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// FSM encoding, default timeout, alignment mask and counter width.
package mem_access_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int unsigned TIMEOUT_CYC_DEF = 15;
   localparam int unsigned CNT_W           = 8;
   localparam logic [1:0]  MISALIGN_MASK   = 2'b11;

endpackage : mem_access_ctrl_pkg

// File: rtl/timeout_cnt.sv
// Clearable 8-bit up-counter; o_tc flags that the count equals TC_VAL.
module timeout_cnt
   import mem_access_ctrl_pkg::*;
#(
   parameter logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC_DEF - 1)
) (
   input  logic i_clk,
   input  logic i_resetn,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      // NOTE: default first so every path assigns count_d and no latch is inferred.
      count_d = count_q;
      if (i_clr)     count_d = '0;
      else if (i_en) count_d = count_q + CNT_W'(1);
   end

   // NOTE: non-blocking assignments in clocked blocks keep every flop sampling pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_resetn) count_q <= '0;
      else           count_q <= count_d;
   end

   assign o_tc = (count_q == TC_VAL);

endmodule : timeout_cnt

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: issues one bus request per load/store,
// stalls the pipeline until ack or timeout, and reports misalignment and bus errors.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic        i_clk,
   input  logic        i_resetn,
   input  logic        i_mem_read,
   input  logic        i_mem_write,
   input  logic [31:0] i_mem_addr,
   input  logic [31:0] i_mem_wdata,
   input  logic        i_flush,
   output logic        o_dm_req,
   output logic        o_dm_we,
   output logic [31:0] o_dm_addr,
   output logic [31:0] o_dm_wdata,
   input  logic        i_dm_ack,
   input  logic [31:0] i_dm_rdata,
   output logic        o_stall,
   output logic [31:0] o_rd_dmem,
   output logic        o_misalign,
   output logic        o_bus_err
);

   state_e      state_q, state_d;
   logic        dm_req_q, dm_req_d;
   logic        dm_we_q, dm_we_d;
   logic [31:0] dm_addr_q, dm_addr_d;
   logic [31:0] dm_wdata_q, dm_wdata_d;
   logic [31:0] rd_dmem_q, rd_dmem_d;
   logic        misalign_q, misalign_d;
   logic        bus_err_q, bus_err_d;

   logic access_req, aligned;
   logic cnt_clr, cnt_en, cnt_tc;

   assign access_req = (i_mem_read | i_mem_write) & ~i_flush;
   assign aligned    = ((i_mem_addr[1:0] & MISALIGN_MASK) == 2'b00);

   timeout_cnt #(
      .TC_VAL (CNT_W'(TIMEOUT_CYC - 1))
   ) u_timeout_cnt (
      .i_clk    (i_clk),
      .i_resetn (i_resetn),
      .i_clr    (cnt_clr),
      .i_en     (cnt_en),
      .o_tc     (cnt_tc)
   );

   always_comb begin
      state_d    = state_q;
      dm_req_d   = dm_req_q;
      dm_we_d    = dm_we_q;
      dm_addr_d  = dm_addr_q;
      dm_wdata_d = dm_wdata_q;
      rd_dmem_d  = rd_dmem_q;
      bus_err_d  = bus_err_q;
      misalign_d = 1'b0;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      o_stall    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (access_req && aligned) begin
               o_stall    = 1'b1;
               state_d    = BUSY;
               dm_req_d   = 1'b1;
               dm_we_d    = i_mem_write;
               dm_addr_d  = i_mem_addr;
               dm_wdata_d = i_mem_wdata;
               cnt_clr    = 1'b1;
            end else if (access_req) begin
               misalign_d = 1'b1;
            end
         end
         BUSY: begin
            o_stall = 1'b1;
            // Ack takes priority over a timeout reached in the same cycle.
            if (i_dm_ack) begin
               state_d  = DONE;
               dm_req_d = 1'b0;
               if (!dm_we_q) rd_dmem_d = i_dm_rdata;
            end else if (cnt_tc) begin
               state_d   = DONE;
               dm_req_d  = 1'b0;
               bus_err_d = 1'b1;
               rd_dmem_d = '0;
            end else begin
               cnt_en = 1'b1;
            end
         end
         // One dead cycle so the still-presented instruction is not re-issued.
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         state_q    <= IDLE;
         dm_req_q   <= 1'b0;
         dm_we_q    <= 1'b0;
         dm_addr_q  <= '0;
         dm_wdata_q <= '0;
         rd_dmem_q  <= '0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         dm_req_q   <= dm_req_d;
         dm_we_q    <= dm_we_d;
         dm_addr_q  <= dm_addr_d;
         dm_wdata_q <= dm_wdata_d;
         rd_dmem_q  <= rd_dmem_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign o_dm_req   = dm_req_q;
   assign o_dm_we    = dm_we_q;
   assign o_dm_addr  = dm_addr_q;
   assign o_dm_wdata = dm_wdata_q;
   assign o_rd_dmem  = rd_dmem_q;
   assign o_misalign = misalign_q;
   assign o_bus_err  = bus_err_q;

endmodule : mem_access_ctrl
